regfile_writeback: RTL

- Write-side master for the 32x32 integer register file port (we/waddr/wdata) in the single-cycle RISC-V core.
- Merges two result producers onto the single write port:
  - the single-cycle ALU path;
  - a long-latency load/store unit (LSU) path, buffered in a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on registers awaiting a load.

---
 rtl/regfile_writeback.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Register-file write master: merges ALU results and FIFO-buffered LSU results onto one write port.
// Latency: a winner appears on we/waddr/wdata one cycle after its accepting edge.
// Backpressure: lsu_ready drops when the FIFO is full; alu_ready drops while the FIFO head is forced (full, or starved under WB_STARVE_GUARD_EN).
module regfile_writeback #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int QDEPTH     = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [AW-1:0]        alu_rd,
  input  logic [DW-1:0]        alu_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [AW-1:0]        lsu_rd,
  input  logic [DW-1:0]        lsu_data,
  output logic                 lsu_ready,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_rd,
  output logic [(1<<AW)-1:0]   busy_vec,
  output logic                 we,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata
);

  localparam int NREG = 1 << AW;
  localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW   = PW + 1;

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || STARVE_LIM < 1) begin : g_param_err
    $error("regfile_writeback: QDEPTH must be a power of two >= 2 and STARVE_LIM >= 1");
  end

  logic [AW-1:0] r_q_rd  [QDEPTH];
  logic [DW-1:0] r_q_dat [QDEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_starve;
  logic            w_fifo_win;
  logic            w_alu_win;
  logic [AW-1:0]   w_head_rd;
  logic [DW-1:0]   w_head_dat;
  logic [NREG-1:0] w_busy_nxt;

  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [NREG-1:0] r_busy;

  assign w_full     = (r_count == CW'(QDEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head_rd  = r_q_rd[r_rptr];
  assign w_head_dat = r_q_dat[r_rptr];

  assign lsu_ready  = !w_full;
  assign w_push     = lsu_valid && lsu_ready;

  // Head is forced when the queue is full (or starved); otherwise it only fills idle ALU slots.
  assign alu_ready  = !w_full && !w_starve;
  assign w_alu_win  = alu_valid && alu_ready;
  assign w_fifo_win = !w_empty && (w_full || w_starve || !alu_valid);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]  <= lsu_rd;
      r_q_dat[r_wptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_fifo_win) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_fifo_win})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_LIM + 1);
  logic [SCW-1:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_fifo_win) begin
      r_starve_cnt <= '0;
    end else if (!w_empty && w_alu_win && r_starve_cnt != SCW'(STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + SCW'(1);
    end
  end

  assign w_starve = !w_empty && (r_starve_cnt == SCW'(STARVE_LIM));
`else
  assign w_starve = 1'b0;
`endif

  // A set in the same cycle as the clear of that register wins; x0 never goes busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_fifo_win && w_head_rd != '0) begin
      w_busy_nxt[w_head_rd] = 1'b0;
    end
    if (sb_set && sb_rd != '0) begin
      w_busy_nxt[sb_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_fifo_win) begin
      r_we    <= (w_head_rd != '0);
      r_waddr <= w_head_rd;
      r_wdata <= w_head_dat;
    end else if (w_alu_win) begin
      r_we    <= (alu_rd != '0);
      r_waddr <= alu_rd;
      r_wdata <= alu_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign busy_vec = r_busy;

endmodule
